// File: rtl/branch_step_ctl.sv
// branch_step_ctl: T0..T6 fetch / conditional-branch control-step sequencer.
// Non-branch opcodes are handed to the execute sequencer via exec_req/exec_done.
// Optional build macro BR_STATS_EN adds taken / not-taken branch counters.
module branch_step_ctl #(
    parameter logic [4:0]  BR_OPCODE = 5'b10010,
    parameter int unsigned CON_WAIT  = 0
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        con,
    input  logic        mem_ready,
    input  logic        exec_done,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        zlow_out,
    output logic        pc_in,
    output logic        mdr_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        exec_req,
    output logic        run,
    output logic [3:0]  step
`ifdef BR_STATS_EN
    ,
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_nt_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_TW   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_EXEC = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               is_branch;
    logic               unused_ir;

    // Opcode decode from the IR loaded during T2
    assign is_branch = (IR[31:27] == BR_OPCODE);
    assign unused_ir = ^IR[26:0];

    // State and CON-settling counter registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic and Moore strobe decode
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        pc_in      = 1'b0;
        mdr_read   = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        gra        = 1'b0;
        r_out      = 1'b0;
        con_in     = 1'b0;
        y_in       = 1'b0;
        c_out      = 1'b0;
        alu_add    = 1'b0;
        exec_req   = 1'b0;
        run        = (state_q != S_IDLE);
        step       = state_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // Re-loading PC from Z while waiting is harmless: Z is not rewritten
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                // Decode point: IR is valid here, non-branches leave without strobes
                if (is_branch) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                    if (CON_WAIT > 0) begin
                        state_d    = S_TW;
                        wait_cnt_d = CNT_W'(CON_WAIT - 1);
                    end else begin
                        state_d = S_T4;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_TW: begin
                if (wait_cnt_q == '0) state_d = S_T4;
                else                  wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
            S_T4: begin
                pc_out  = 1'b1;
                y_in    = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                c_out   = 1'b1;
                alu_add = 1'b1;
                z_in    = 1'b1;
                state_d = S_T6;
            end
            S_T6: begin
                zlow_out = 1'b1;
                pc_in    = con;
                state_d  = stop ? S_IDLE : S_T0;
            end
            S_EXEC: begin
                exec_req = 1'b1;
                if (exec_done) state_d = stop ? S_IDLE : S_T0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef BR_STATS_EN
    logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [STAT_W-1:0] nt_cnt_q, nt_cnt_d;

    // Branch outcome counters, bumped as T6 is left
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        nt_cnt_d    = nt_cnt_q;
        if (state_q == S_T6) begin
            if (con) taken_cnt_d = taken_cnt_q + STAT_W'(1);
            else     nt_cnt_d    = nt_cnt_q + STAT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
        end
    end

    assign br_taken_cnt = taken_cnt_q;
    assign br_nt_cnt    = nt_cnt_q;
`endif

endmodule

// File: tb/tb_branch_step_ctl.sv
// Scoreboard bench for branch_step_ctl: one instance with CON_WAIT=0, one with CON_WAIT=3.
module tb_branch_step_ctl;

    typedef struct packed {
        logic [3:0]  step;
        logic [17:0] outs;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        start;
    logic        stop;
    logic [31:0] IR;
    logic        con;
    logic        mem_ready;
    logic        exec_done;

    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mdr_read, mdr_in, mdr_out, ir_in;
    logic gra, r_out, con_in, y_in, c_out, alu_add, exec_req, run;
    logic [3:0] step;
    logic pc_out_w, mar_in_w, inc_pc_w, z_in_w, zlow_out_w, pc_in_w, mdr_read_w, mdr_in_w;
    logic mdr_out_w, ir_in_w, gra_w, r_out_w, con_in_w, y_in_w, c_out_w, alu_add_w;
    logic exec_req_w, run_w;
    logic [3:0] step_w;
`ifdef BR_STATS_EN
    logic [15:0] br_taken_cnt, br_nt_cnt, br_taken_cnt_w, br_nt_cnt_w;
`endif

    logic [17:0] obs0, obs3;
    exp_t        exp_q[$];
    int          checks;
    int          errors;

    localparam logic [31:0] IR_BR  = 32'h9000_0000;
    localparam logic [31:0] IR_ALU = 32'h0800_0000;

    branch_step_ctl #(.BR_OPCODE(5'b10010), .CON_WAIT(0)) u_dut (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .IR(IR), .con(con),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
        .zlow_out(zlow_out), .pc_in(pc_in), .mdr_read(mdr_read), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out), .con_in(con_in),
        .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .exec_req(exec_req),
        .run(run), .step(step)
`ifdef BR_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_nt_cnt(br_nt_cnt)
`endif
    );

    branch_step_ctl #(.BR_OPCODE(5'b10010), .CON_WAIT(3)) u_dut_w (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .IR(IR), .con(con),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .pc_out(pc_out_w), .mar_in(mar_in_w), .inc_pc(inc_pc_w), .z_in(z_in_w),
        .zlow_out(zlow_out_w), .pc_in(pc_in_w), .mdr_read(mdr_read_w), .mdr_in(mdr_in_w),
        .mdr_out(mdr_out_w), .ir_in(ir_in_w), .gra(gra_w), .r_out(r_out_w),
        .con_in(con_in_w), .y_in(y_in_w), .c_out(c_out_w), .alu_add(alu_add_w),
        .exec_req(exec_req_w), .run(run_w), .step(step_w)
`ifdef BR_STATS_EN
        , .br_taken_cnt(br_taken_cnt_w), .br_nt_cnt(br_nt_cnt_w)
`endif
    );

    assign obs0 = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mdr_read, mdr_in,
                   mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add, exec_req, run};
    assign obs3 = {pc_out_w, mar_in_w, inc_pc_w, z_in_w, zlow_out_w, pc_in_w, mdr_read_w,
                   mdr_in_w, mdr_out_w, ir_in_w, gra_w, r_out_w, con_in_w, y_in_w,
                   c_out_w, alu_add_w, exec_req_w, run_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference strobe table per control step (bit 17 pc_out ... bit 0 run)
    function automatic exp_t exp_for(input int st, input logic br, input logic c);
        exp_t e;
        e.step = 4'(st);
        e.outs = '0;
        e.outs[0] = (st != 0);
        case (st)
            1: begin e.outs[17] = 1'b1; e.outs[16] = 1'b1; e.outs[15] = 1'b1; e.outs[14] = 1'b1; end
            2: begin e.outs[13] = 1'b1; e.outs[12] = 1'b1; e.outs[11] = 1'b1; e.outs[10] = 1'b1; end
            3: begin e.outs[9] = 1'b1; e.outs[8] = 1'b1; end
            4: begin e.outs[7] = br; e.outs[6] = br; e.outs[5] = br; end
            6: begin e.outs[17] = 1'b1; e.outs[4] = 1'b1; end
            7: begin e.outs[3] = 1'b1; e.outs[2] = 1'b1; e.outs[14] = 1'b1; end
            8: begin e.outs[13] = 1'b1; e.outs[12] = c; end
            9: begin e.outs[1] = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Pulse clear for two cycles; released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        clear = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   seq[6] = '{0, 0, 0, 1, 2, 3};
        clear = 1'b1; start = 1'b1; stop = 1'b0; mem_ready = 1'b1;
        exec_done = 1'b0; con = 1'b1; IR = IR_BR;
        foreach (seq[i]) exp_q.push_back(exp_for(seq[i], 1'b1, 1'b1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step, obs0} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL reset[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         i, step, obs0, e.step, e.outs);
            end
            if (i == 2) clear = 1'b0;
        end
    endtask

    task automatic test_branch(input logic c);
        exp_t e;
        int   seq[9] = '{1, 2, 3, 4, 6, 7, 8, 1, 2};
        IR = IR_BR; con = c; start = 1'b1; stop = 1'b0; mem_ready = 1'b1; exec_done = 1'b0;
        do_reset();
`ifdef BR_STATS_EN
        checks++;
        if (br_taken_cnt !== 16'd0 || br_nt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: taken=%0d nt=%0d, expected 0 0", br_taken_cnt, br_nt_cnt);
        end
`endif
        foreach (seq[i]) exp_q.push_back(exp_for(seq[i], 1'b1, c));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step, obs0} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL branch_con%0d[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         c, i, step, obs0, e.step, e.outs);
            end
        end
`ifdef BR_STATS_EN
        checks++;
        if (br_taken_cnt !== 16'(c) || br_nt_cnt !== 16'(!c)) begin
            errors++;
            $display("FAIL stats_con%0d: taken=%0d nt=%0d, expected %0d %0d",
                     c, br_taken_cnt, br_nt_cnt, c, !c);
        end
`endif
    endtask

    task automatic test_mem_wait();
        exp_t e;
        int   seq[7] = '{1, 2, 2, 2, 2, 3, 4};
        logic mr[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        IR = IR_BR; con = 1'b1; start = 1'b1; stop = 1'b0; mem_ready = 1'b1; exec_done = 1'b0;
        do_reset();
        foreach (seq[i]) exp_q.push_back(exp_for(seq[i], 1'b1, 1'b1));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step, obs0} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL mem_wait[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         i, step, obs0, e.step, e.outs);
            end
            mem_ready = mr[i];
        end
    endtask

    task automatic test_exec_handoff();
        exp_t e;
        int   seq[12] = '{1, 2, 3, 4, 9, 9, 9, 9, 9, 0, 0, 1};
        logic st_v[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic sp_v[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic dn_v[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        IR = IR_ALU; con = 1'b1; start = 1'b1; stop = 1'b0; mem_ready = 1'b1; exec_done = 1'b0;
        do_reset();
        foreach (seq[i]) exp_q.push_back(exp_for(seq[i], 1'b0, 1'b1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step, obs0} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL exec[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         i, step, obs0, e.step, e.outs);
            end
            start = st_v[i]; stop = sp_v[i]; exec_done = dn_v[i];
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_con_wait_clear();
        exp_t e;
        int   pre[6]   = '{1, 2, 3, 4, 5, 5};
        int   post[11] = '{1, 2, 3, 4, 5, 5, 5, 6, 7, 8, 1};
        IR = IR_BR; con = 1'b1; start = 1'b1; stop = 1'b0; mem_ready = 1'b1; exec_done = 1'b0;
        do_reset();
        foreach (pre[i]) exp_q.push_back(exp_for(pre[i], 1'b1, 1'b1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step_w, obs3} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL wait_pre[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         i, step_w, obs3, e.step, e.outs);
            end
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({step_w, obs3} !== 22'd0) begin
            errors++;
            $display("FAIL async_clear: step=%0d outs=%h, expected step=0 outs=0", step_w, obs3);
        end
        @(negedge clk);
        clear = 1'b0;
        foreach (post[i]) exp_q.push_back(exp_for(post[i], 1'b1, 1'b1));
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({step_w, obs3} !== {e.step, e.outs}) begin
                errors++;
                $display("FAIL wait_run[%0d]: step=%0d outs=%h, expected step=%0d outs=%h",
                         i, step_w, obs3, e.step, e.outs);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b1; start = 1'b0; stop = 1'b0; IR = '0; con = 1'b0;
        mem_ready = 1'b0; exec_done = 1'b0;
        test_reset();
        test_branch(1'b1);
        test_branch(1'b0);
        test_mem_wait();
        test_exec_handoff();
        test_con_wait_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
